// File: rtl/uart7n_echo_buffer_pkg.sv
// uart7n_echo_buffer_pkg
// Shared constants for the UART 7N echo buffer: the character width used by
// the UART core and the encodings of the transmit-side handshake states.
// Optional build macro (used by the top level): UART7N_ECHO_ERR_DROP_EN.
package uart7n_echo_buffer_pkg;

    // Character width of the UART core this buffer sits behind.
    localparam int DATA_WIDTH = 7;

    // Transmit handshake state encodings, kept as plain 2-bit constants so
    // they line up with the legacy include-file values.
    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_START     = 2'd1;
    localparam logic [1:0] ST_WAIT_BUSY = 2'd2;
    localparam logic [1:0] ST_WAIT_DONE = 2'd3;

endpackage

// File: rtl/uart7n_echo_buffer_sync_fifo.sv
// uart7n_sync_fifo
// Single-clock FIFO used to park received characters until the transmitter
// can take them. A write arriving while full is accepted only when a read
// happens on the same edge, because the read frees the slot first.
// Read data is registered and holds its value until the next read.
module uart7n_sync_fifo
    import uart7n_echo_buffer_pkg::*;
#(
    parameter int p_width     = DATA_WIDTH,
    parameter int p_depth     = 16,
    parameter int p_cnt_width = 5
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr_en,
    input  logic [p_width-1:0]     wr_data,
    input  logic                   rd_en,
    output logic [p_width-1:0]     rd_data,
    output logic [p_cnt_width-1:0] count,
    output logic                   full,
    output logic                   empty
);

    // Pointers are one bit narrower than the count; with a power-of-two
    // depth they wrap modulo the depth on their own.
    localparam int ptr_width = p_cnt_width - 1;

    logic [p_width-1:0]   mem [p_depth];
    logic [ptr_width-1:0] wr_ptr;
    logic [ptr_width-1:0] rd_ptr;
    logic                 do_wr;
    logic                 do_rd;

    assign full  = (count == p_cnt_width'(p_depth));
    assign empty = (count == '0);

    assign do_rd = rd_en & ~empty;
    assign do_wr = wr_en & (~full | do_rd);

    // Storage array; left unreset since the count decides what is valid.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Write pointer advances on every accepted write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
        end else if (do_wr) begin
            wr_ptr <= wr_ptr + ptr_width'(1);
        end
    end

    // Read pointer advances and the head is latched into rd_data on a read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr  <= '0;
            rd_data <= '0;
        end else if (do_rd) begin
            rd_ptr  <= rd_ptr + ptr_width'(1);
            rd_data <= mem[rd_ptr];
        end
    end

    // Occupancy moves by +1, -1 or stays put when a write and read coincide.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else begin
            case ({do_wr, do_rd})
                2'b10:   count <= count + p_cnt_width'(1);
                2'b01:   count <= count - p_cnt_width'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart7n_echo_buffer.sv
// uart7n_echo_buffer
// Glue between the UART 7N receiver and transmitter. Every rising edge of
// the receiver's data-ready level stores one character in a FIFO; the FIFO
// is drained one character at a time into the transmitter with a one-cycle
// start pulse, following the transmitter's busy handshake.
// Build macro UART7N_ECHO_ERR_DROP_EN: when defined, characters flagged with
// a parity/framing error are discarded at capture; otherwise rx_err_i is
// ignored and every character is stored.
module uart7n_echo_buffer
    import uart7n_echo_buffer_pkg::*;
#(
    parameter int p_data_width = DATA_WIDTH,
    parameter int p_depth      = 16,
    parameter int p_cnt_width  = 5
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic                    rx_data_ready_i,
    input  logic [p_data_width-1:0] rx_data_i,
    input  logic                    rx_err_i,
    input  logic                    tx_en_i,
    input  logic                    tx_busy_i,
    output logic                    tx_start_o,
    output logic [p_data_width-1:0] tx_data_o,
    output logic [p_cnt_width-1:0]  fifo_count_o,
    output logic                    fifo_empty_o,
    output logic                    fifo_full_o,
    output logic                    overflow_o,
    input  logic                    clr_ovf_i
);

    logic       rdy_q;
    logic       capture;
    logic       wr;
    logic       pop;
    logic [1:0] state;

    // A capture is the first cycle of a high data-ready level, so a level
    // held for many cycles still produces exactly one write.
    assign capture = rx_data_ready_i & ~rdy_q;

`ifdef UART7N_ECHO_ERR_DROP_EN
    // Errored characters never reach the FIFO and cannot cause an overflow.
    assign wr = capture & ~rx_err_i;
`else
    // Error flag is intentionally ignored in this build.
    logic unused_rx_err;
    assign unused_rx_err = rx_err_i;
    assign wr = capture;
`endif

    // The head is popped only from IDLE; dropping tx_en_i elsewhere lets the
    // character already handed to the transmitter finish normally.
    assign pop = (state == ST_IDLE) & tx_en_i & ~fifo_empty_o;

    // Start pulse is a pure decode of the START state, so it lasts one cycle.
    assign tx_start_o = (state == ST_START);

    uart7n_sync_fifo #(
        .p_width     (p_data_width),
        .p_depth     (p_depth),
        .p_cnt_width (p_cnt_width)
    ) u_fifo (
        .clk     (clk_i),
        .rst_n   (rst_n_i),
        .wr_en   (wr),
        .wr_data (rx_data_i),
        .rd_en   (pop),
        .rd_data (tx_data_o),
        .count   (fifo_count_o),
        .full    (fifo_full_o),
        .empty   (fifo_empty_o)
    );

    // Delayed copy of data-ready used for rising-edge detection.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rdy_q <= 1'b0;
        end else begin
            rdy_q <= rx_data_ready_i;
        end
    end

    // Sticky overflow: set when a write is lost, a new loss wins over clear.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            overflow_o <= 1'b0;
        end else if (wr & fifo_full_o & ~pop) begin
            overflow_o <= 1'b1;
        end else if (clr_ovf_i) begin
            overflow_o <= 1'b0;
        end
    end

    // Transmit handshake: pop, pulse start, wait for busy to rise then fall.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pop) begin
                        state <= ST_START;
                    end
                end
                ST_START: begin
                    state <= ST_WAIT_BUSY;
                end
                ST_WAIT_BUSY: begin
                    if (tx_busy_i) begin
                        state <= ST_WAIT_DONE;
                    end
                end
                ST_WAIT_DONE: begin
                    if (!tx_busy_i) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart7n_echo_buffer.sv
// tb_uart7n_echo_buffer
// Self-checking bench for uart7n_echo_buffer. A queue-based reference model
// predicts every output each cycle; directed scenarios add hand-computed
// expectations, and a randomized phase exercises mixed traffic.
// Honours UART7N_ECHO_ERR_DROP_EN the same way as the design.
module tb_uart7n_echo_buffer;

    localparam int W     = 7;
    localparam int DEPTH = 16;
    localparam int CW    = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          rx_rdy = 1'b0;
    logic [W-1:0]  rx_data = '0;
    logic          rx_err = 1'b0;
    logic          tx_en = 1'b0;
    logic          tx_busy;
    logic          tx_start;
    logic [W-1:0]  tx_data;
    logic [CW-1:0] fifo_count;
    logic          fifo_empty;
    logic          fifo_full;
    logic          overflow;
    logic          clr = 1'b0;

    logic busy_force = 1'b0;
    logic busy_auto  = 1'b0;
    int   busy_delay = 2;
    int   busy_len   = 20;
    int   wait_cnt   = 0;
    int   hold_cnt   = 0;

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;
    bit check_en     = 0;

    int           pulse_count = 0;
    int           pulse_cyc[$];
    logic [W-1:0] seen[$];

    assign tx_busy = busy_force | busy_auto;

    always #5 clk = ~clk;

    uart7n_echo_buffer #(
        .p_data_width (W),
        .p_depth      (DEPTH),
        .p_cnt_width  (CW)
    ) dut (
        .clk_i           (clk),
        .rst_n_i         (rst_n),
        .rx_data_ready_i (rx_rdy),
        .rx_data_i       (rx_data),
        .rx_err_i        (rx_err),
        .tx_en_i         (tx_en),
        .tx_busy_i       (tx_busy),
        .tx_start_o      (tx_start),
        .tx_data_o       (tx_data),
        .fifo_count_o    (fifo_count),
        .fifo_empty_o    (fifo_empty),
        .fifo_full_o     (fifo_full),
        .overflow_o      (overflow),
        .clr_ovf_i       (clr)
    );

    // Single comparison point: counts every check, reports failures.
    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    // One receiver character: data-ready high for 'hold' cycles, then low.
    task automatic applyStimulus(input logic [W-1:0] d, input logic err, input int hold);
        rx_data = d;
        rx_err  = err;
        rx_rdy  = 1'b1;
        tick(hold);
        rx_rdy  = 1'b0;
        rx_err  = 1'b0;
        tick(1);
    endtask

    task automatic waitPulses(input int target, input int budget);
        int n = 0;
        while (pulse_count < target && n < budget) begin
            tick(1);
            n++;
        end
        if (pulse_count < target) begin
            checkOutput("pulse_wait_timeout", pulse_count, target);
        end
    endtask

    // Cycle counter used to measure start-pulse latency.
    always @(posedge clk) cyc++;

    // Transmitter stand-in: raises busy a few cycles after each start pulse.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (tx_start) begin
                wait_cnt = busy_delay;
                hold_cnt = busy_len;
            end else if (wait_cnt > 0) begin
                wait_cnt--;
                if (wait_cnt == 0) busy_auto = 1'b1;
            end else if (hold_cnt > 0) begin
                hold_cnt--;
                if (hold_cnt == 0) busy_auto = 1'b0;
            end
        end
    end

    // Reference model: a character queue plus flags for where the echo
    // channel stands (pulse showing, awaiting busy high, awaiting busy low).
    logic [W-1:0] mq[$];
    bit           m_prev_rdy, m_ovf, m_pulse, m_need_hi, m_need_lo;
    logic [W-1:0] m_data;
    bit           m_cap, m_pop, m_free, m_ovf_ev;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            m_prev_rdy = 0;
            m_ovf      = 0;
            m_pulse    = 0;
            m_need_hi  = 0;
            m_need_lo  = 0;
            m_data     = '0;
        end else begin
            m_cap = rx_rdy && !m_prev_rdy;
`ifdef UART7N_ECHO_ERR_DROP_EN
            if (rx_err) m_cap = 0;
`endif
            m_prev_rdy = rx_rdy;
            m_free = !m_pulse && !m_need_hi && !m_need_lo;
            m_pop  = m_free && tx_en && (mq.size() > 0);
            if (m_pulse) begin
                m_need_hi = 1;
            end else if (m_need_hi && tx_busy) begin
                m_need_hi = 0;
                m_need_lo = 1;
            end else if (m_need_lo && !tx_busy) begin
                m_need_lo = 0;
            end
            m_pulse = m_pop;
            if (m_pop) m_data = mq.pop_front();
            m_ovf_ev = 0;
            if (m_cap) begin
                if (mq.size() < DEPTH) mq.push_back(rx_data);
                else m_ovf_ev = 1;
            end
            if (m_ovf_ev) m_ovf = 1;
            else if (clr) m_ovf = 0;
        end
    end

    // Compare every output against the model each cycle and log start pulses.
    always @(negedge clk) begin
        if (check_en) begin
            checkOutput("tx_start", tx_start, m_pulse);
            checkOutput("tx_data", tx_data, m_data);
            checkOutput("fifo_count", fifo_count, mq.size());
            checkOutput("fifo_empty", fifo_empty, mq.size() == 0);
            checkOutput("fifo_full", fifo_full, mq.size() == DEPTH);
            checkOutput("overflow", overflow, m_ovf);
        end
        if (tx_start === 1'b1) begin
            pulse_count++;
            pulse_cyc.push_back(cyc);
            seen.push_back(tx_data);
        end
    end

    logic [W-1:0] ovch[17];
    logic [W-1:0] sim_ch;
    int           p0;
    int           drive_cyc;

    initial begin
        rst_n = 1'b0;
        tick(3);
        checkOutput("reset_count", fifo_count, 0);
        checkOutput("reset_empty", fifo_empty, 1);
        checkOutput("reset_full", fifo_full, 0);
        checkOutput("reset_start", tx_start, 0);
        checkOutput("reset_ovf", overflow, 0);
        checkOutput("reset_data", tx_data, 0);
        rst_n = 1'b1;
        check_en = 1;
        tick(2);

        // Single character, data-ready held for 5 cycles.
        tx_en = 1'b1;
        busy_delay = 2;
        busy_len = 20;
        p0 = pulse_count;
        drive_cyc = cyc;
        applyStimulus(7'h41, 1'b0, 5);
        waitPulses(p0 + 1, 50);
        tick(40);
        checkOutput("single_pulses", pulse_count - p0, 1);
        if (pulse_count > p0) begin
            checkOutput("single_latency", pulse_cyc[p0] - drive_cyc, 2);
            checkOutput("single_data", seen[p0], 7'h41);
        end
        checkOutput("single_count", fifo_count, 0);

        // Burst while the transmitter is held busy and draining is paused.
        busy_len = 3;
        busy_force = 1'b1;
        tx_en = 1'b0;
        p0 = pulse_count;
        for (int i = 1; i <= 4; i++) applyStimulus(W'(i), 1'b0, 2);
        tick(2);
        checkOutput("burst_count", fifo_count, 4);
        tx_en = 1'b1;
        tick(6);
        checkOutput("burst_first_pulse", pulse_count - p0, 1);
        checkOutput("burst_count_held", fifo_count, 3);
        busy_force = 1'b0;
        waitPulses(p0 + 4, 200);
        tick(20);
        for (int i = 0; i < 4; i++) begin
            if (pulse_count > p0 + i) checkOutput("burst_order", seen[p0 + i], i + 1);
        end

        // Overflow: 17 captures into a 16-deep FIFO with draining paused.
        tx_en = 1'b0;
        tick(5);
        for (int i = 0; i < 17; i++) begin
            ovch[i] = W'($urandom_range(0, 127));
            applyStimulus(ovch[i], 1'b0, 2);
        end
        tick(2);
        checkOutput("ovf_full", fifo_full, 1);
        checkOutput("ovf_count", fifo_count, 16);
        checkOutput("ovf_flag", overflow, 1);
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        tick(1);
        checkOutput("ovf_cleared", overflow, 0);

        // Full FIFO: enable and capture edge land in the same cycle.
        sim_ch = W'($urandom_range(0, 127));
        p0 = pulse_count;
        tx_en = 1'b1;
        rx_data = sim_ch;
        rx_rdy = 1'b1;
        tick(1);
        rx_rdy = 1'b0;
        tick(1);
        checkOutput("sim_count", fifo_count, 16);
        checkOutput("sim_ovf", overflow, 0);
        waitPulses(p0 + 17, 17 * 15 + 50);
        tick(20);
        for (int i = 0; i < 17; i++) begin
            if (pulse_count > p0 + i) checkOutput("drain_order", seen[p0 + i], (i < 16) ? ovch[i] : sim_ch);
        end
        checkOutput("drain_total", pulse_count - p0, 17);

        // Asynchronous reset while a character is mid-transmission.
        busy_len = 20;
        tx_en = 1'b0;
        for (int i = 0; i < 4; i++) applyStimulus(W'(8'h60 + i), 1'b0, 2);
        p0 = pulse_count;
        tx_en = 1'b1;
        waitPulses(p0 + 1, 20);
        tx_en = 1'b0;
        tick(8);
        checkOutput("pre_reset_count", fifo_count, 3);
        #1;
        rst_n = 1'b0;
        busy_auto = 1'b0;
        wait_cnt = 0;
        hold_cnt = 0;
        #1;
        checkOutput("async_reset_start", tx_start, 0);
        checkOutput("async_reset_count", fifo_count, 0);
        checkOutput("async_reset_empty", fifo_empty, 1);
        tick(2);
        rst_n = 1'b1;
        tx_en = 1'b1;
        p0 = pulse_count;
        tick(30);
        checkOutput("post_reset_pulses", pulse_count - p0, 0);

        // Character flagged with a receive error.
        busy_len = 3;
        p0 = pulse_count;
        applyStimulus(7'h55, 1'b1, 3);
        tick(30);
`ifdef UART7N_ECHO_ERR_DROP_EN
        checkOutput("err_drop_pulses", pulse_count - p0, 0);
        checkOutput("err_drop_count", fifo_count, 0);
`else
        checkOutput("err_echo_pulses", pulse_count - p0, 1);
        if (pulse_count > p0) checkOutput("err_echo_data", seen[p0], 7'h55);
`endif

        // Randomized mixed traffic, checked cycle by cycle against the model.
        for (int i = 0; i < 1500; i++) begin
            rx_rdy     = ($urandom_range(0, 2) == 0);
            rx_data    = W'($urandom_range(0, 127));
            rx_err     = ($urandom_range(0, 3) == 0);
            tx_en      = ($urandom_range(0, 4) != 0);
            clr        = ($urandom_range(0, 19) == 0);
            busy_delay = $urandom_range(1, 4);
            busy_len   = $urandom_range(1, 6);
            tick(1);
        end
        rx_rdy = 1'b0;
        rx_err = 1'b0;
        clr = 1'b0;
        tx_en = 1'b1;
        tick(600);
        checkOutput("final_empty", fifo_empty, 1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
